// File: rtl/ili9341_init_seq.sv
// ili9341_init_seq: power-up sequencer for an ILI9341 panel. It pulses the panel
// hardware reset, then walks the init-command ROM and streams each entry to the SPI
// byte transmitter, inserting the wake-up delay after SLPOUT (command 0x11).
// Latency: at least 3 cycles per byte (FETCH, LATCH, SEND); SEND holds the byte until spi_ready.
// Optional build macro INIT_SEQ_TIMEOUT_EN: adds a SEND-stall timeout and the ERR state.
// Ports:
//   clk, rst_n (sync, active low), start (pulse, accepted in IDLE/DONE/ERR)
//   rom_addr / rom_data      : command ROM, data valid one edge after address change
//   spi_valid/spi_dc/spi_data/spi_ready : byte handshake to the SPI transmitter
//   lcd_rst_n                : panel hardware reset, active low
//   busy / done / err        : sequencer status
module ili9341_init_seq #(
  parameter int ROM_AW          = 6,
  parameter int ROM_DEPTH       = 64,
  parameter int RST_LOW_CYC     = 10000,
  parameter int RST_WAIT_CYC    = 600000,
  parameter int SLPOUT_WAIT_CYC = 6000000,
  parameter int TIMEOUT_CYC     = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [9:0]        rom_data,
  output logic              spi_valid,
  output logic              spi_dc,
  output logic [7:0]        spi_data,
  input  logic              spi_ready,
  output logic              lcd_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_LOW, S_RST_WAIT, S_FETCH, S_LATCH, S_SEND, S_DELAY,
`ifdef INIT_SEQ_TIMEOUT_EN
    S_DONE, S_ERR
`else
    S_DONE
`endif
  } state_t;

  // Terminal counts; a length of 0 behaves as 1 cycle.
  localparam logic [31:0] LOW_LAST  = (RST_LOW_CYC     > 1) ? 32'(RST_LOW_CYC - 1)     : 32'd0;
  localparam logic [31:0] WAIT_LAST = (RST_WAIT_CYC    > 1) ? 32'(RST_WAIT_CYC - 1)    : 32'd0;
  localparam logic [31:0] SLP_LAST  = (SLPOUT_WAIT_CYC > 1) ? 32'(SLPOUT_WAIT_CYC - 1) : 32'd0;
  localparam logic [31:0] TO_LAST   = (TIMEOUT_CYC     > 1) ? 32'(TIMEOUT_CYC - 1)     : 32'd0;
  localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(ROM_DEPTH - 1);

  state_t      state, state_nx;
  logic [31:0] cnt;
  logic        last_entry;
  logic        is_slpout;
  logic        is_term;
  logic        unused_bits;

  assign last_entry = (rom_addr == LAST_ADDR);
  assign is_slpout  = !spi_dc && (spi_data == 8'h11);
  // Terminator is decoded straight from the ROM word while it is being latched.
  assign is_term    = !rom_data[8] && (rom_data[7:0] == 8'hFF);
  // Reserved ROM bit is ignored; TO_LAST is only consumed in the timeout build.
  assign unused_bits = ^{rom_data[9], TO_LAST};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_RST_LOW;
      S_RST_LOW:  if (cnt == LOW_LAST) state_nx = S_RST_WAIT;
      S_RST_WAIT: if (cnt == WAIT_LAST) state_nx = S_FETCH;
      S_FETCH:    state_nx = S_LATCH;
      S_LATCH:    state_nx = is_term ? S_DONE : S_SEND;
      S_SEND: begin
        if (spi_ready) begin
          if (is_slpout)       state_nx = S_DELAY;
          else if (last_entry) state_nx = S_DONE;
          else                 state_nx = S_FETCH;
        end
`ifdef INIT_SEQ_TIMEOUT_EN
        // cnt restarts on SEND entry and SEND is only held while spi_ready is low,
        // so here cnt equals the number of stalled cycles already seen.
        else if (cnt == TO_LAST) begin
          state_nx = S_ERR;
        end
`endif
      end
      S_DELAY:    if (cnt == SLP_LAST) state_nx = last_entry ? S_DONE : S_FETCH;
      S_DONE:     if (start) state_nx = S_RST_LOW;
`ifdef INIT_SEQ_TIMEOUT_EN
      S_ERR:      if (start) state_nx = S_RST_LOW;
`endif
      default:    state_nx = S_IDLE;
    endcase
  end

  // Datapath: shared cycle counter, ROM address and latched byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= 32'd0;
      rom_addr <= '0;
      spi_dc   <= 1'b0;
      spi_data <= 8'h00;
    end else begin
      // Counter restarts on every state change, so each state sees 0..N-1.
      cnt <= (state_nx != state) ? 32'd0 : cnt + 32'd1;
      if (state == S_LATCH) begin
        spi_dc   <= rom_data[8];
        spi_data <= rom_data[7:0];
      end
      if (state_nx == S_FETCH && state != S_FETCH) begin
        rom_addr <= (state == S_RST_WAIT) ? '0 : rom_addr + ROM_AW'(1);
      end
    end
  end

  // Output logic
  always_comb begin
    spi_valid = (state == S_SEND);
    lcd_rst_n = (state != S_RST_LOW);
    done      = (state == S_DONE);
`ifdef INIT_SEQ_TIMEOUT_EN
    err       = (state == S_ERR);
    busy      = !(state == S_IDLE || state == S_DONE || state == S_ERR);
`else
    err       = 1'b0;
    busy      = !(state == S_IDLE || state == S_DONE);
`endif
  end

endmodule

// File: doc/ili9341_init_seq.md
Name: ili9341_init_seq

Overview:
- Sequencer that walks the ILI9341 init-command ROM after power-up and streams each entry to the SPI byte transmitter over a valid/ready handshake.
- Performs the panel hardware-reset pulse first, then inserts the mandatory delay after SLPOUT (0x11).
- Stops at the 0xFF terminator command and reports done.
- Sits between the command ROM and the SPI transmitter; releases the SPI link to the pixel path once done is high.

Parameters:
- ROM_AW, 6: ROM address width.
- ROM_DEPTH, 64: number of ROM entries; the last valid index is ROM_DEPTH-1.
- RST_LOW_CYC, 10000: cycles lcd_rst_n is held low.
- RST_WAIT_CYC, 600000: cycles to wait after lcd_rst_n is released, before the first command.
- SLPOUT_WAIT_CYC, 6000000: cycles to wait after command 0x11 completes.
- TIMEOUT_CYC, 65535: cycles without spi_ready before an error (optional feature only).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a sequence from IDLE or DONE.
- rom_addr  out  ROM_AW  ROM address, registered.
- rom_data  in  10  ROM word {bit9 reserved (ignored), bit8 dc, bits7:0 byte}; valid one rising edge after rom_addr changes.
- spi_valid  out  1  byte offered to the transmitter.
- spi_dc  out  1  0 = command, 1 = parameter.
- spi_data  out  8  byte to send.
- spi_ready  in  1  transmitter accepts the byte when spi_valid && spi_ready at a rising edge.
- lcd_rst_n  out  1  panel hardware reset, active low.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- done  out  1  high in DONE.
- err  out  1  high in ERR (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_n=0 at a rising edge) values:
  - state=IDLE, rom_addr=0, spi_valid=0, spi_dc=0, spi_data=0x00.
  - lcd_rst_n=1, busy=0, done=0, err=0, delay counter=0.
  - Reset mid-sequence aborts immediately; no byte is completed afterwards.
- IDLE: start -> RST_LOW, counter=0, lcd_rst_n=0.
- RST_LOW: lcd_rst_n=0 for exactly RST_LOW_CYC cycles -> RST_WAIT, lcd_rst_n=1.
- RST_WAIT: RST_WAIT_CYC cycles -> FETCH, rom_addr=0.
- FETCH: rom_addr stable for one cycle -> LATCH.
- LATCH: capture rom_data into spi_dc/spi_data, then decode:
  - dc=0 and byte=0xFF is the terminator -> DONE; nothing is sent.
  - Otherwise -> SEND with spi_valid=1.
- SEND: hold spi_valid, spi_dc and spi_data stable until spi_ready is high. On the accepting edge, spi_valid=0 and:
  - If the sent byte was dc=0, 0x11 -> DELAY, counter=0.
  - Else if rom_addr==ROM_DEPTH-1 -> DONE (missing terminator; no wrap).
  - Else rom_addr+1 -> FETCH.
- DELAY: SLPOUT_WAIT_CYC cycles, then rom_addr+1 -> FETCH. The ROM_DEPTH-1 check also applies here.
- DONE: done=1, spi_valid=0. start -> RST_LOW; rom_addr is reset to 0 on entry to FETCH.
- start in any busy state is ignored.
- Throughput: minimum 3 cycles per byte (FETCH, LATCH, SEND with spi_ready already high).
- Only dc=0 triggers the SLPOUT delay: a parameter byte (dc=1) of 0x11 or 0xFF is sent normally.
- Delay counter is 32 bits, counts 0..N-1. A parameter value of 0 behaves as 1 cycle.
- spi_ready while spi_valid=0 has no effect.

Optional Feature:
- Macro: INIT_SEQ_TIMEOUT_EN.
- Defined:
  - In SEND, a counter increments each cycle spi_ready=0 and clears on entry to SEND.
  - Reaching TIMEOUT_CYC -> ERR: spi_valid=0, err=1, busy=0.
  - ERR exits only via rst_n or start; start restarts from RST_LOW and clears err.
- Undefined: no counter and no ERR state; SEND waits indefinitely; err is tied 0.

Test Plan:
- RST_LOW_CYC=4, RST_WAIT_CYC=8, start pulse -> lcd_rst_n low for exactly 4 cycles, first spi_valid no earlier than 8 cycles after release, busy=1 throughout.
- ROM {0x0CB, 0x139, 0x0FF}, spi_ready tied 1 -> handshakes (dc0,0xCB) then (dc1,0x39), 3 cycles apart; done=1 with no third byte; rom_addr stops at 2.
- ROM {0x011, 0x029, 0x0FF}, SLPOUT_WAIT_CYC=16 -> gap between 0x11 acceptance and 0x29 spi_valid is ≥16+2 cycles; entry 0x111 (dc=1) causes no delay.
- spi_ready held low 20 cycles then high -> spi_valid, spi_dc and spi_data stable all 20 cycles; exactly one transfer.
- rst_n low while in SEND with the third byte pending -> next cycle spi_valid=0, lcd_rst_n=1, busy=0; a later start replays the sequence from address 0.
- INIT_SEQ_TIMEOUT_EN, TIMEOUT_CYC=10, spi_ready=0 -> err=1 after 10 SEND cycles, spi_valid=0; start then clears err and drives lcd_rst_n low.
